alu_req_arbiter: RTL and testbench

- Round-robin arbiter sharing one ALU operand/result path among 4 requesters.
- Drives the select of the existing 4:1 mux bank and registers the winning beat into a single-entry output stage with valid/ready handshake.
- Sits between the requester front-ends and the ALU input register.

---
 rtl/alu_arb_pkg.sv | 14 +
 rtl/alu_req_arbiter_rr_pick4.sv | 27 ++
 rtl/alu_req_arbiter.sv | 106 ++++++++++
 tb/tb_alu_req_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants and FSM encoding for the ALU request arbiter.
package alu_arb_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_IDX_W = 2;

    localparam logic [ARB_IDX_W-1:0] PTR_RST = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_rr_pick4.sv
// Rotate-priority encoder: searches ptr+1, ptr+2, ptr+3, ptr (mod 4) for the first request.
module rr_pick4
    import alu_arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] win,
    output logic                 win_valid
);

    logic [ARB_IDX_W-1:0] idx;

    // Walk lowest priority first so the highest-priority hit is the last write.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        idx       = '0;
        for (int k = ARB_N; k >= 1; k--) begin
            idx = ptr + ARB_IDX_W'(k);
            if (req[idx]) begin
                win       = idx;
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter for 4 requesters feeding a single-entry valid/ready output stage.
// Optional build macro ALU_ARB_LOCK_EN adds req_lock for multi-beat locked grants.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ARB_N-1:0]       req_valid,
    input  logic [ARB_N*DATA_W-1:0] req_data,
`ifdef ALU_ARB_LOCK_EN
    input  logic [ARB_N-1:0]       req_lock,
`endif
    output logic [ARB_N-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [ARB_IDX_W-1:0]   out_src,
    output logic [ARB_IDX_W-1:0]   mux_sel,
    output logic                   busy
);

    arb_state_e           state_q, state_d;
    logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
    logic [ARB_IDX_W-1:0] src_q, src_d;
    logic [DATA_W-1:0]    data_q, data_d;

    logic [ARB_IDX_W-1:0] pick_win;
    logic                 pick_valid;
    logic [ARB_IDX_W-1:0] win;
    logic                 win_valid;
    logic                 can_take;
    logic                 load;

    rr_pick4 u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .win       (pick_win),
        .win_valid (pick_valid)
    );

`ifdef ALU_ARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked only the current owner may be granted, even when it is not requesting.
    always_comb begin
        win       = lock_q ? src_q : pick_win;
        win_valid = lock_q ? req_valid[src_q] : pick_valid;
        lock_d    = load ? req_lock[win] : lock_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_d;
    end
`else
    assign win       = pick_win;
    assign win_valid = pick_valid;
`endif

    assign can_take = (state_q == IDLE) || out_ready;
    assign load     = can_take && win_valid;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        data_d    = data_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: if (load) state_d = FULL;
            FULL: if (out_ready && !win_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            ptr_d  = win;
            src_d  = win;
            data_d = req_data[int'(win)*DATA_W +: DATA_W];
            if (!rst) req_ready[win] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign busy      = out_valid;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign mux_sel   = win_valid ? win : src_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_lock = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [1:0]  mux_sel;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_src;
    int       m_ptr;
    bit       m_lock;

    always #5 clk = ~clk;

    alu_req_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .mux_sel   (mux_sel),
        .busy      (busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_lock = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void m_pick(input logic [3:0] rv, output bit v, output int idx);
        v = 1'b0;
        idx = 0;
        if (m_lock) begin
            v = rv[m_src];
            idx = m_src;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c = (m_ptr + k) % 4;
                if (!v && rv[c]) begin
                    v = 1'b1;
                    idx = c;
                end
            end
        end
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        n_checks++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src got %0d exp 0", out_src); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        n_checks++; if (mux_sel !== 2'd0) begin n_fail++; $display("FAIL reset_mux_sel got %0d exp 0", mux_sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int exp_src[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h44_33_22_11;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (req_ready !== (4'b0001 << exp_src[i])) begin n_fail++; $display("FAIL rr_req_ready[%0d] got %b exp src %0d", i, req_ready, exp_src[i]); end
            @(posedge clk); #1;
            n_checks++; if (out_src !== 2'(exp_src[i])) begin n_fail++; $display("FAIL rr_out_src[%0d] got %0d exp %0d", i, out_src, exp_src[i]); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_out_valid[%0d] got %b exp 1", i, out_valid); end
            n_checks++; if (out_data !== 8'(8'h11 * (exp_src[i] + 1))) begin n_fail++; $display("FAIL rr_out_data[%0d] got %h", i, out_data); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h00_A5_00_00;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
        n_checks++; if (mux_sel !== 2'd2) begin n_fail++; $display("FAIL single_mux_sel got %0d exp 2", mux_sel); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (out_data !== 8'hA5 || out_src !== 2'd2) begin n_fail++; $display("FAIL single_out got %h/%0d exp a5/2", out_data, out_src); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_one_pulse got %b exp 0000", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_retain got %h exp a5", out_data); end
        n_checks++; if (mux_sel !== 2'd2) begin n_fail++; $display("FAIL single_idle_mux got %0d exp 2", mux_sel); end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'hD4_C3_B2_A1;
        @(negedge clk);
        out_ready = 1'b0;
        req_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_req_ready[%0d] got %b exp 0000", i, req_ready); end
            n_checks++; if (out_data !== 8'hA1 || out_src !== 2'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got %h/%0d/%b exp a1/0/1", i, out_data, out_src, out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_resume_ready got %b exp 0010", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_src !== 2'd1 || out_data !== 8'hB2) begin n_fail++; $display("FAIL stall_resume_out got %0d/%h exp 1/b2", out_src, out_data); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_alternate();
        int exp_src[3] = '{3, 1, 3};
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_src !== 2'(exp_src[i])) begin n_fail++; $display("FAIL alt_src[%0d] got %0d exp %0d", i, out_src, exp_src[i]); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b1000;
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b exp 0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b0110;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL async_rst_first got %b exp 0010", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_src !== 2'd1) begin n_fail++; $display("FAIL async_rst_src got %0d exp 1", out_src); end
        @(negedge clk);
        req_valid = '0;
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        int exp_src[5] = '{1, 1, 1, 1, 2};
        do_reset();
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_valid = 4'b1111;
            if (i == 3) req_lock = 4'b0000;
            @(posedge clk); #1;
            n_checks++; if (out_src !== 2'(exp_src[i])) begin n_fail++; $display("FAIL lock_src[%0d] got %0d exp %0d", i, out_src, exp_src[i]); end
            @(negedge clk);
        end
        req_valid = '0;
        req_lock  = '0;
    endtask
`endif

    task automatic test_random();
        bit   v, can, xfer;
        int   idx;
        logic [3:0] exp_rdy;
        logic [1:0] exp_mux;
        do_reset();
        m_valid = 0; m_data = 0; m_src = 0; m_ptr = 3; m_lock = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom % 4) != 0;
`ifdef ALU_ARB_LOCK_EN
            req_lock  = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
`endif
            #1;
            m_pick(req_valid, v, idx);
            can  = !m_valid || out_ready;
            xfer = can && v;
            exp_rdy = xfer ? (4'b0001 << idx) : 4'b0000;
            exp_mux = v ? 2'(idx) : 2'(m_src);
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_req_ready c%0d got %b exp %b", cyc, req_ready, exp_rdy); end
            n_checks++; if (mux_sel !== exp_mux) begin n_fail++; $display("FAIL rnd_mux_sel c%0d got %0d exp %0d", cyc, mux_sel, exp_mux); end
            n_checks++; if (out_valid !== m_valid || busy !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b/%b exp %b", cyc, out_valid, busy, m_valid); end
            n_checks++; if (out_data !== m_data || out_src !== 2'(m_src)) begin n_fail++; $display("FAIL rnd_out c%0d got %h/%0d exp %h/%0d", cyc, out_data, out_src, m_data, m_src); end
            if (xfer) begin
                m_valid = 1;
                m_data  = req_data[idx*8 +: 8];
                m_src   = idx;
                m_ptr   = idx;
`ifdef ALU_ARB_LOCK_EN
                m_lock  = req_lock[idx];
`endif
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_alternate();
        test_async_reset();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
